irq_pending_ctrl: RTL and testbench
===================================

Name: irq_pending_ctrl

Overview:
- Interrupt-request front end that sits directly upstream of the 4-to-2 priority encoder.
- Edge-detects four request lines and latches them into a pending register. The masked pending vector (pend_out) drives the encoder's Y input.
- Offers the highest-priority pending request to a service agent over a valid/ack handshake, then blocks in service until done.
- Priority order matches the encoder: bit 3 highest, bit 0 lowest.

Parameters:
- N, 4, number of request lines. Fixed at 4 to match the 4-bit encoder input.
- IDW, 2, width of irq_id (clog2(N)).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- irq_in  in  N  level request lines, already synchronous to clk
- irq_mask  in  N  1 = line masked (still latched, not offered)
- pend_out  out  N  pending & ~irq_mask; feeds encoder Y
- irq_valid  out  1  offer valid
- irq_id  out  IDW  index of offered request; stable while irq_valid=1
- irq_ack  in  1  agent accepts offer (meaningful only with irq_valid=1)
- irq_done  in  1  single-cycle pulse: service finished
- busy  out  1  1 while in SERVICE

Behaviour:
- Reset (async, active-high; may assert at any time, including mid-handshake):
  - pending=0, irq_prev=0, state=IDLE.
  - irq_valid=0, irq_id=0, busy=0, pend_out=0.
- Edge detect:
  - edge = irq_in & ~irq_prev; irq_prev <= irq_in every cycle; pending <= pending | edge.
  - A line already high at reset release counts as an edge.
  - A held level produces exactly one pending set.
- pend_out = pending & ~irq_mask. It is decoded from registers only, with no combinational path from inputs.
- FSM states IDLE, OFFER, SERVICE:
  - IDLE:
    - If pend_out != 0, go to OFFER next edge.
    - Latch irq_id = highest set index of pend_out; irq_valid <= 1.
    - Latency: irq_in first sampled high at edge E0 → pending set at E0 → irq_valid=1 after E1.
  - OFFER:
    - irq_valid=1, irq_id held stable.
    - No re-arbitration on higher-priority arrivals or mask changes.
    - On irq_ack at edge Ea: irq_valid <= 0, pending[irq_id] <= 0, go to SERVICE.
  - SERVICE:
    - busy=1.
    - On irq_done: go to IDLE. The earliest next irq_valid is one edge after done.
    - New edges keep accumulating in pending; there is no preemption.
- Simultaneous events:
  - Edge on bit irq_id in the same cycle as ack: the set wins, the bit stays pending and is re-offered later.
  - Several edges in one cycle are all latched.
- Ignored inputs:
  - irq_ack outside OFFER.
  - irq_done outside SERVICE, including done in the same cycle as ack.
- Masking:
  - Masked bits remain pending indefinitely.
  - Clearing the mask makes them eligible at the next IDLE evaluation.
- irq_id holds its last value while irq_valid=0.

Decomposition:
- Shared package:
  - State encodings ST_IDLE=2'd0, ST_OFFER=2'd1, ST_SERVICE=2'd2.
  - N and IDW defaults.
- One natural sub-module: irq_edge_latch.
  - Contents: irq_prev, the edge detect, and the pending register with set/clear-by-index.
  - Set priority over clear is implemented here.
- Top level: FSM, highest-index select, and handshake outputs.

Test Plan:
- Reset: hold rst=1 during OFFER with irq_id=10 → immediately irq_valid=0, busy=0, pend_out=0000, irq_id=00. On release with irq_in=0001 → irq_valid=1, id=00 two edges later.
- Single request: irq_in 0000→0001 → irq_valid=1 after 2 edges, id=00, pend_out=0001. Ack → valid=0, pend_out=0000, busy=1. Done → busy=0, no further offer.
- Simultaneous 0110: offer id=10. After ack+done, offer id=01 with pend_out=0010. After its ack+done, pend_out=0000.
- Mask: irq_mask=1000, irq_in rises to 1010 → pend_out=0010, id=01. Ack+done, then clear mask → pend_out=1000 and offer id=11.
- Level vs edge: hold irq_in=0100 through ack/done → no second offer. Drop to 0000 then raise → new offer id=10.
- Ack/edge collision: offer id=00 and pulse irq_in[0] 0→1 in the ack cycle → after done, id=00 offered again. In the same test, irq_done during OFFER is ignored (state stays OFFER, valid=1).

Source files
------------

// File: rtl/irq_pending_ctrl_pkg.sv
// rtl/irq_pending_ctrl_pkg.sv - shared encodings, sizes and priority select for the irq front end
package irq_pending_ctrl_pkg;

  localparam int IRQ_N   = 4;
  localparam int IRQ_IDW = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Bit 3 wins, matching the downstream 4-to-2 encoder.
  function automatic logic [IRQ_IDW-1:0] highest_idx(input logic [IRQ_N-1:0] v);
    logic [IRQ_IDW-1:0] idx;
    idx = '0;
    for (int i = 0; i < IRQ_N; i++) begin
      if (v[i]) idx = IRQ_IDW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// rtl/irq_edge_latch.sv - rising-edge detect and pending register with set-over-clear by index
module irq_edge_latch
  import irq_pending_ctrl_pkg::*;
#(
  parameter int N   = IRQ_N,
  parameter int IDW = IRQ_IDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   irq_in,
  input  logic           clr_en,
  input  logic [IDW-1:0] clr_idx,
  output logic [N-1:0]   pending
);

  logic [N-1:0] irq_prev_q, irq_prev_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] edge_det;
  logic [N-1:0] clr_vec;

  always_comb begin
    irq_prev_d = irq_in;
    edge_det   = irq_in & ~irq_prev_q;
    clr_vec    = '0;
    if (clr_en) clr_vec[clr_idx] = 1'b1;
    // A fresh edge on the bit being acknowledged must survive the clear.
    pending_d  = (pending_q & ~clr_vec) | edge_det;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - pending/mask front end offering the top request over valid/ack, blocking until done
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter int N   = IRQ_N,
  parameter int IDW = IRQ_IDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   irq_in,
  input  logic [N-1:0]   irq_mask,
  output logic [N-1:0]   pend_out,
  output logic           irq_valid,
  output logic [IDW-1:0] irq_id,
  input  logic           irq_ack,
  input  logic           irq_done,
  output logic           busy
);

  irq_state_e     state_q, state_d;
  logic [IDW-1:0] irq_id_q, irq_id_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [N-1:0]   pending;
  logic           clr_en;
  logic [IDW-1:0] clr_idx;

  irq_edge_latch #(.N(N), .IDW(IDW)) u_edge_latch (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .clr_en  (clr_en),
    .clr_idx (clr_idx),
    .pending (pending)
  );

  // The mask is registered so pend_out is a pure function of flops.
  assign pend_out = pending & ~mask_q;

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    mask_d   = irq_mask;
    clr_en   = 1'b0;
    clr_idx  = irq_id_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend_out) begin
          state_d  = ST_OFFER;
          irq_id_d = highest_idx(pend_out);
        end
      end
      ST_OFFER: begin
        if (irq_ack) begin
          clr_en  = 1'b1;
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (irq_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      irq_id_q <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
      mask_q   <= mask_d;
    end
  end

  assign irq_valid = (state_q == ST_OFFER);
  assign busy      = (state_q == ST_SERVICE);
  assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb/tb_irq_pending_ctrl.sv - directed self-checking bench for irq_pending_ctrl
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_in;
  logic [3:0] irq_mask;
  logic [3:0] pend_out;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ack;
  logic       irq_done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .irq_mask  (irq_mask),
    .pend_out  (pend_out),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .irq_done  (irq_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ack_cycle();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic done_cycle();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_in = 4'b0000; irq_mask = 4'b0000; irq_ack = 1'b0; irq_done = 1'b0;
    #1;
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL por_valid got %b exp 0", irq_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL por_busy got %b exp 0", busy); end
    checks++; if (pend_out !== 4'b0000) begin errors++; $display("FAIL por_pend got %b exp 0000", pend_out); end
    tick(); tick();
    rst = 1'b0;
    irq_in = 4'b0100;
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL rst_pre_offer got v=%b id=%0d exp v=1 id=2", irq_valid, irq_id); end
    #2 rst = 1'b1;
    #1;
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", irq_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    checks++; if (pend_out !== 4'b0000) begin errors++; $display("FAIL rst_mid_pend got %b exp 0000", pend_out); end
    checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL rst_mid_id got %0d exp 0", irq_id); end
    irq_in = 4'b0001;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (irq_valid !== 1'b0 || pend_out !== 4'b0001) begin errors++; $display("FAIL rst_rel_e1 got v=%b p=%b exp v=0 p=0001", irq_valid, pend_out); end
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL rst_rel_offer got v=%b id=%0d exp v=1 id=0", irq_valid, irq_id); end
    ack_cycle(); done_cycle();
    irq_in = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    irq_in = 4'b0001;
    tick();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", irq_valid); end
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 2'd0 || pend_out !== 4'b0001) begin errors++; $display("FAIL single_offer got v=%b id=%0d p=%b exp v=1 id=0 p=0001", irq_valid, irq_id, pend_out); end
    ack_cycle();
    checks++; if (irq_valid !== 1'b0 || pend_out !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL single_ack got v=%b p=%b b=%b exp v=0 p=0000 b=1", irq_valid, pend_out, busy); end
    done_cycle();
    checks++; if (busy !== 1'b0 || irq_valid !== 1'b0) begin errors++; $display("FAIL single_done got b=%b v=%b exp b=0 v=0", busy, irq_valid); end
    tick(); tick();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL single_no_reoffer got %b exp 0", irq_valid); end
    checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL single_id_hold got %0d exp 0", irq_id); end
    irq_in = 4'b0000;
    tick();
  endtask

  task automatic test_simultaneous();
    irq_in = 4'b0110;
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 2'd2 || pend_out !== 4'b0110) begin errors++; $display("FAIL simul_first got v=%b id=%0d p=%b exp v=1 id=2 p=0110", irq_valid, irq_id, pend_out); end
    ack_cycle();
    checks++; if (pend_out !== 4'b0010 || busy !== 1'b1) begin errors++; $display("FAIL simul_ack got p=%b b=%b exp p=0010 b=1", pend_out, busy); end
    done_cycle();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL simul_gap got %b exp 0", irq_valid); end
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 2'd1 || pend_out !== 4'b0010) begin errors++; $display("FAIL simul_second got v=%b id=%0d p=%b exp v=1 id=1 p=0010", irq_valid, irq_id, pend_out); end
    ack_cycle(); done_cycle();
    checks++; if (pend_out !== 4'b0000 || irq_valid !== 1'b0) begin errors++; $display("FAIL simul_empty got p=%b v=%b exp p=0000 v=0", pend_out, irq_valid); end
    irq_in = 4'b0000;
    tick();
  endtask

  task automatic test_mask();
    irq_mask = 4'b1000;
    irq_in   = 4'b1010;
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 2'd1 || pend_out !== 4'b0010) begin errors++; $display("FAIL mask_offer got v=%b id=%0d p=%b exp v=1 id=1 p=0010", irq_valid, irq_id, pend_out); end
    ack_cycle(); done_cycle();
    tick(); tick();
    checks++; if (irq_valid !== 1'b0 || pend_out !== 4'b0000) begin errors++; $display("FAIL mask_held got v=%b p=%b exp v=0 p=0000", irq_valid, pend_out); end
    irq_mask = 4'b0000;
    tick();
    checks++; if (pend_out !== 4'b1000) begin errors++; $display("FAIL mask_clear_pend got %b exp 1000", pend_out); end
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 2'd3) begin errors++; $display("FAIL mask_clear_offer got v=%b id=%0d exp v=1 id=3", irq_valid, irq_id); end
    ack_cycle(); done_cycle();
    irq_in = 4'b0000;
    tick();
  endtask

  task automatic test_level();
    irq_in = 4'b0100;
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL level_offer got v=%b id=%0d exp v=1 id=2", irq_valid, irq_id); end
    ack_cycle(); done_cycle();
    tick(); tick(); tick();
    checks++; if (irq_valid !== 1'b0 || pend_out !== 4'b0000) begin errors++; $display("FAIL level_held got v=%b p=%b exp v=0 p=0000", irq_valid, pend_out); end
    irq_in = 4'b0000;
    tick();
    irq_in = 4'b0100;
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL level_rearm got v=%b id=%0d exp v=1 id=2", irq_valid, irq_id); end
    ack_cycle(); done_cycle();
    irq_in = 4'b0000;
    tick();
  endtask

  task automatic test_collision();
    irq_in = 4'b0001;
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL coll_offer got v=%b id=%0d exp v=1 id=0", irq_valid, irq_id); end
    done_cycle();
    checks++; if (irq_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL coll_done_in_offer got v=%b b=%b exp v=1 b=0", irq_valid, busy); end
    irq_in = 4'b0000;
    tick();
    irq_in   = 4'b0001;
    irq_ack  = 1'b1;
    irq_done = 1'b1;
    tick();
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    checks++; if (busy !== 1'b1 || irq_valid !== 1'b0 || pend_out !== 4'b0001) begin errors++; $display("FAIL coll_ack got b=%b v=%b p=%b exp b=1 v=0 p=0001", busy, irq_valid, pend_out); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coll_service_hold got %b exp 1", busy); end
    done_cycle();
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL coll_reoffer got v=%b id=%0d exp v=1 id=0", irq_valid, irq_id); end
    ack_cycle(); done_cycle();
    irq_in = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_mask();
    test_level();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
